// File: rtl/ifu_pkg.sv
// Shared IFU constants and types for the instruction-buffer fill path.
package ifu_pkg;

  localparam int unsigned IBUF_DEPTH      = 16;
  localparam int unsigned IBUF_FILL_BYTES = 4;
  localparam int unsigned IBUF_CNT_W      = 5;
  localparam int unsigned SHIFT_LEN_W     = 3;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/ibuf_shift.sv
// Combinational next-state of the instruction byte array: drain s bytes toward the head,
// then append the accepted fill bytes behind the survivors; everything beyond is zero.
module ibuf_shift
  import ifu_pkg::*;
#(
  parameter int unsigned Depth     = IBUF_DEPTH,
  parameter int unsigned FillBytes = IBUF_FILL_BYTES,
  parameter int unsigned CntW      = IBUF_CNT_W
) (
  input  byte_t [Depth-1:0]       bytes_cur,
  input  logic  [CntW-1:0]        shift,
  input  logic  [CntW-1:0]        keep_cnt,
  input  logic  [CntW-1:0]        fill_cnt,
  input  logic  [8*FillBytes-1:0] fill_data,
  output byte_t [Depth-1:0]       bytes_next
);

  logic  [8*Depth-1:0]   shifted;
  logic  [8*Depth-1:0]   keep_mask;
  logic  [8*Depth-1:0]   fill_vec;
  byte_t [FillBytes-1:0] fill_masked;

  always_comb begin
    shifted = bytes_cur >> {shift, 3'b000};
    for (int i = 0; i < Depth; i++) begin
      keep_mask[8*i +: 8] = (CntW'(i) < keep_cnt) ? 8'hFF : 8'h00;
    end
    // Bytes past the beat length are don't-care on the bus; zero them so no stale data lands.
    for (int k = 0; k < FillBytes; k++) begin
      fill_masked[k] = (CntW'(k) < fill_cnt) ? fill_data[8*k +: 8] : 8'h00;
    end
    fill_vec   = (8*Depth)'(fill_masked) << {keep_cnt, 3'b000};
    bytes_next = (shifted & keep_mask) | fill_vec;
  end

endmodule

// File: rtl/ibuf_fill_ctl.sv
// Instruction-buffer writer/drain control: byte shift buffer, fill handshake, sticky error.
module ibuf_fill_ctl
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH      = IBUF_DEPTH,
  parameter int unsigned FILL_BYTES = IBUF_FILL_BYTES,
  parameter int unsigned CNT_W      = IBUF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    icu_vld,
  input  logic [8*FILL_BYTES-1:0] icu_data,
  input  logic [2:0]              icu_nbytes,
  output logic                    icu_rdy,
  input  logic [SHIFT_LEN_W-1:0]  iu_shift_len,
  input  logic                    iu_flush,
  output logic [55:0]             ibuf_top,
  output logic [6:0]              fetch_valid,
  output logic [CNT_W-1:0]        ibuf_cnt,
  output logic                    ibuf_err
);

  byte_t [DEPTH-1:0] bytes_q, bytes_d, bytes_next;
  logic  [CNT_W-1:0] cnt_q, cnt_d;
  logic  [CNT_W-1:0] shift_req, shift_eff, keep_cnt, fill_cnt;
  logic              err_q, err_d;
  logic              over_shift, nbytes_ok, accept;

  // Readiness looks only at the registered count so it never waits on the decode stage.
  assign icu_rdy = ~reset & ~iu_flush & (cnt_q <= CNT_W'(DEPTH - FILL_BYTES));

  always_comb begin
    shift_req  = CNT_W'(iu_shift_len);
    over_shift = shift_req > cnt_q;
    shift_eff  = over_shift ? cnt_q : shift_req;
    keep_cnt   = cnt_q - shift_eff;
    nbytes_ok  = (icu_nbytes != 3'd0) && (32'(icu_nbytes) <= FILL_BYTES);
    accept     = icu_vld & icu_rdy;
    fill_cnt   = (accept & nbytes_ok) ? CNT_W'(icu_nbytes) : '0;
  end

  ibuf_shift #(
    .Depth     (DEPTH),
    .FillBytes (FILL_BYTES),
    .CntW      (CNT_W)
  ) u_shift (
    .bytes_cur  (bytes_q),
    .shift      (shift_eff),
    .keep_cnt   (keep_cnt),
    .fill_cnt   (fill_cnt),
    .fill_data  (icu_data),
    .bytes_next (bytes_next)
  );

  always_comb begin
    cnt_d   = keep_cnt + fill_cnt;
    bytes_d = bytes_next;
    err_d   = err_q | over_shift | (accept & ~nbytes_ok);
    if (iu_flush) begin
      cnt_d   = '0;
      bytes_d = '0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      bytes_q <= '0;
      err_q   <= 1'b0;
    end else begin
      assert (cnt_d <= CNT_W'(DEPTH));
      cnt_q   <= cnt_d;
      bytes_q <= bytes_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    for (int k = 0; k < 7; k++) begin
      fetch_valid[k] = cnt_q > CNT_W'(k);
    end
  end

  assign ibuf_top = bytes_q[6:0];
  assign ibuf_cnt = cnt_q;
  assign ibuf_err = err_q;

endmodule

// File: tb/tb_ibuf_fill_ctl.sv
// Directed bench for ibuf_fill_ctl with hand-computed expectations.
module tb_ibuf_fill_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        icu_vld;
  logic [31:0] icu_data;
  logic [2:0]  icu_nbytes;
  logic        icu_rdy;
  logic [2:0]  iu_shift_len;
  logic        iu_flush;
  logic [55:0] ibuf_top;
  logic [6:0]  fetch_valid;
  logic [4:0]  ibuf_cnt;
  logic        ibuf_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ibuf_fill_ctl dut (
    .clk          (clk),
    .reset        (reset),
    .icu_vld      (icu_vld),
    .icu_data     (icu_data),
    .icu_nbytes   (icu_nbytes),
    .icu_rdy      (icu_rdy),
    .iu_shift_len (iu_shift_len),
    .iu_flush     (iu_flush),
    .ibuf_top     (ibuf_top),
    .fetch_valid  (fetch_valid),
    .ibuf_cnt     (ibuf_cnt),
    .ibuf_err     (ibuf_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    icu_vld      = 1'b0;
    icu_data     = 32'h0;
    icu_nbytes   = 3'd0;
    iu_shift_len = 3'd0;
    iu_flush     = 1'b0;
  endtask

  task automatic fill(input logic [31:0] data, input logic [2:0] n, input logic [2:0] sh);
    icu_vld      = 1'b1;
    icu_data     = data;
    icu_nbytes   = n;
    iu_shift_len = sh;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    check("rst_cnt", 64'(ibuf_cnt), 64'd0);
    check("rst_fv", 64'(fetch_valid), 64'h0);
    check("rst_top", 64'(ibuf_top), 64'h0);
    check("rst_err", 64'(ibuf_err), 64'h0);
    check("rst_rdy", 64'(icu_rdy), 64'h0);
    reset = 1'b0;
    #1;
    check("rdy_empty", 64'(icu_rdy), 64'h1);

    // Four full beats 0x00..0x0F.
    fill(32'h03020100, 3'd4, 3'd0); tick();
    fill(32'h07060504, 3'd4, 3'd0); tick();
    fill(32'h0B0A0908, 3'd4, 3'd0); tick();
    check("rdy_cnt12", 64'(icu_rdy), 64'h1);
    fill(32'h0F0E0D0C, 3'd4, 3'd0); tick();
    check("full_cnt", 64'(ibuf_cnt), 64'd16);
    check("full_rdy", 64'(icu_rdy), 64'h0);
    check("full_top", 64'(ibuf_top), 64'h06050403020100);
    check("full_fv", 64'(fetch_valid), 64'h7F);

    // Shift 5 from full; offered beat must be refused.
    fill(32'hDEADBEEF, 3'd4, 3'd5);
    #1;
    check("refuse_rdy", 64'(icu_rdy), 64'h0);
    tick();
    check("sh5_cnt", 64'(ibuf_cnt), 64'd11);
    check("sh5_top", 64'(ibuf_top), 64'h0B0A0908070605);

    fill(32'h00000010, 3'd1, 3'd0); tick();
    check("c12_cnt", 64'(ibuf_cnt), 64'd12);

    // Simultaneous shift 7 and full beat at cnt = DEPTH-4.
    fill(32'hA3A2A1A0, 3'd4, 3'd7); tick();
    check("sf_cnt", 64'(ibuf_cnt), 64'd9);
    check("sf_top", 64'(ibuf_top), 64'hA1A0100F0E0D0C);
    check("sf_err", 64'(ibuf_err), 64'h0);

    idle(); iu_shift_len = 3'd2; tick();
    check("sh2_cnt", 64'(ibuf_cnt), 64'd7);
    check("sh2_top", 64'(ibuf_top), 64'hA3A2A1A0100F0E);

    fill(32'h00001122, 3'd2, 3'd0); tick();
    check("c9_cnt", 64'(ibuf_cnt), 64'd9);

    // Flush overrides fill and shift.
    fill(32'h12345678, 3'd4, 3'd3);
    iu_flush = 1'b1;
    #1;
    check("flush_rdy", 64'(icu_rdy), 64'h0);
    tick();
    idle();
    check("flush_cnt", 64'(ibuf_cnt), 64'd0);
    check("flush_fv", 64'(fetch_valid), 64'h0);
    check("flush_top", 64'(ibuf_top), 64'h0);
    check("flush_err", 64'(ibuf_err), 64'h0);

    fill(32'h00004433, 3'd2, 3'd0); tick();
    check("c2_top", 64'(ibuf_top), 64'h4433);
    fill(32'hFFFFFF55, 3'd1, 3'd0); tick();
    check("n1_cnt", 64'(ibuf_cnt), 64'd3);
    check("n1_fv", 64'(fetch_valid), 64'h07);
    check("n1_top", 64'(ibuf_top), 64'h554433);

    idle(); iu_shift_len = 3'd1; tick();
    check("sh1_top", 64'(ibuf_top), 64'h5544);

    // Over-long shift clamps and sets the sticky error.
    iu_shift_len = 3'd5; tick();
    check("over_cnt", 64'(ibuf_cnt), 64'd0);
    check("over_err", 64'(ibuf_err), 64'h1);
    check("over_top", 64'(ibuf_top), 64'h0);

    fill(32'h01020304, 3'd4, 3'd0); tick();
    idle();
    check("sticky_cnt", 64'(ibuf_cnt), 64'd4);
    check("sticky_top", 64'(ibuf_top), 64'h01020304);
    check("sticky_err", 64'(ibuf_err), 64'h1);

    reset = 1'b1; tick(); reset = 1'b0;
    check("clr_err", 64'(ibuf_err), 64'h0);
    check("clr_cnt", 64'(ibuf_cnt), 64'd0);

    // Illegal beat lengths are dropped and flagged.
    fill(32'h000000AA, 3'd0, 3'd0); tick();
    idle();
    check("n0_cnt", 64'(ibuf_cnt), 64'd0);
    check("n0_err", 64'(ibuf_err), 64'h1);
    check("n0_top", 64'(ibuf_top), 64'h0);

    reset = 1'b1; tick(); reset = 1'b0;
    fill(32'hCAFEBABE, 3'd5, 3'd0); tick();
    idle();
    check("n5_cnt", 64'(ibuf_cnt), 64'd0);
    check("n5_err", 64'(ibuf_err), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
